// File: rtl/dac_update_if.sv
// dac_update_if: requester A/B handshakes and the SPI-controller update port
interface dac_update_if;
  logic        a_req;
  logic        a_all;
  logic [4:0]  a_channel;
  logic [11:0] a_value;
  logic        a_grant;
  logic        a_done;
  logic        a_err;
  logic        b_req;
  logic        b_all;
  logic [4:0]  b_channel;
  logic [11:0] b_value;
  logic        b_grant;
  logic        b_done;
  logic        b_err;
  logic [4:0]  dac_target_channel;
  logic [11:0] dac_single_value;
  logic        dac_update_single;
  logic        dac_update_all;
  logic        dac_busy;
  logic        dac_update_complete;
  modport slave (
    input  a_req, a_all, a_channel, a_value, b_req, b_all, b_channel, b_value,
    input  dac_busy, dac_update_complete,
    output a_grant, a_done, a_err, b_grant, b_done, b_err,
    output dac_target_channel, dac_single_value, dac_update_single, dac_update_all
  );
  modport master (
    output a_req, a_all, a_channel, a_value, b_req, b_all, b_channel, b_value,
    output dac_busy, dac_update_complete,
    input  a_grant, a_done, a_err, b_grant, b_done, b_err,
    input  dac_target_channel, dac_single_value, dac_update_single, dac_update_all
  );
endinterface

// File: rtl/dac_update_arbiter.sv
// dac_update_arbiter: round-robin sharing of the DAC update port between A, B and a refresh timer
module dac_update_arbiter #(
  parameter int REFRESH_PERIOD = 500000,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_CH         = 24
) (
  input  logic         clk,
  input  logic         rst,
  dac_update_if.slave  bus,
  input  logic         refresh_en_i,
  output logic [1:0]   owner_o,
  output logic [7:0]   timeout_count_o
);
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] N_CH = 6'(NUM_CH);
  localparam logic [1:0] SRC_A = 2'd1;
  localparam logic [1:0] SRC_B = 2'd2;
  localparam logic [1:0] SRC_R = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic          all_q, all_d;
  logic          bad_q, bad_d;
  logic          err_q, err_d;
  logic [4:0]    ch_q, ch_d;
  logic [11:0]   val_q, val_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    tout_q, tout_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pend_q, pend_d;
  logic [3:0]    req;
  logic [1:0]    c0, c1, c2, win;
  logic          w_all, w_bad, take, wrap;
  logic [4:0]    w_ch;
  logic [11:0]   w_val;

  // ptr_q indexes sources 0=A, 1=B, 2=refresh and names the first one looked at
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin winner and its payload; refresh always counts as an all-channel update
  always_comb begin
    req = {1'b0, pend_q, bus.b_req, bus.a_req};
    c0 = ptr_q;
    c1 = nxt(ptr_q);
    c2 = nxt(c1);
    win = req[c0] ? c0 + 2'd1 : req[c1] ? c1 + 2'd1 : req[c2] ? c2 + 2'd1 : 2'd0;
    w_all = win == SRC_R || (win == SRC_A ? bus.a_all : bus.b_all);
    w_ch = win == SRC_A ? bus.a_channel : bus.b_channel;
    w_val = win == SRC_A ? bus.a_value : bus.b_value;
    w_bad = !w_all && {1'b0, w_ch} >= N_CH;
    take = state_q == IDLE && !bus.dac_busy && win != 2'd0;
    wrap = rcnt_q == R_LAST;
  end

  // Transaction FSM next state plus the registered payload, timeout and pointer updates
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    all_d = all_q;
    bad_d = bad_q;
    err_d = err_q;
    ch_d = ch_q;
    val_d = val_q;
    tcnt_d = tcnt_q;
    tout_d = tout_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = ISSUE;
        owner_d = win;
        ptr_d = nxt(win - 2'd1);
        all_d = w_all;
        bad_d = w_bad;
        ch_d = w_all || w_bad ? ch_q : w_ch;
        val_d = w_all || w_bad ? val_q : w_val;
      end
      ISSUE: begin
        tcnt_d = '0;
        err_d = bad_q;
        state_d = bad_q ? DONE : WAIT_DONE;
      end
      WAIT_DONE: begin
        tcnt_d = tcnt_q + TW'(1);
        if (bus.dac_update_complete) begin
          err_d = 1'b0;
          state_d = DONE;
        end else if (tcnt_q == T_LAST) begin
          err_d = 1'b1;
          tout_d = tout_q == 8'hFF ? tout_q : tout_q + 8'd1;
          state_d = DONE;
        end
      end
      default: begin
        owner_d = 2'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Refresh timer: a wrap raises one pending refresh, a refresh grant clears it
  always_comb begin
    rcnt_d = !refresh_en_i || wrap ? '0 : rcnt_q + RW'(1);
    pend_d = !refresh_en_i ? 1'b0 : wrap ? 1'b1 : take && win == SRC_R ? 1'b0 : pend_q;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Datapath registers; reset abandons any transaction in flight without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
      owner_q <= 2'd0;
      all_q <= 1'b0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      ch_q <= '0;
      val_q <= '0;
      tcnt_q <= '0;
      tout_q <= '0;
      rcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      all_q <= all_d;
      bad_q <= bad_d;
      err_q <= err_d;
      ch_q <= ch_d;
      val_q <= val_d;
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
      rcnt_q <= rcnt_d;
      pend_q <= pend_d;
    end
  end

  assign bus.a_grant = state_q == ISSUE && owner_q == SRC_A;
  assign bus.b_grant = state_q == ISSUE && owner_q == SRC_B;
  assign bus.dac_update_all = state_q == ISSUE && all_q;
  assign bus.dac_update_single = state_q == ISSUE && !all_q && !bad_q;
  assign bus.a_done = state_q == DONE && owner_q == SRC_A;
  assign bus.b_done = state_q == DONE && owner_q == SRC_B;
  assign bus.a_err = state_q == DONE && owner_q == SRC_A && err_q;
  assign bus.b_err = state_q == DONE && owner_q == SRC_B && err_q;
  assign bus.dac_target_channel = ch_q;
  assign bus.dac_single_value = val_q;
  assign owner_o = owner_q;
  assign timeout_count_o = tout_q;
endmodule

// File: tb/tb_dac_update_arbiter.sv
// tb_dac_update_arbiter: scoreboard bench for the DAC update arbiter
module tb_dac_update_arbiter;
  localparam int T = 120;
  localparam int R = 50;
  localparam logic [2:0] K_GA = 3'd1;
  localparam logic [2:0] K_GB = 3'd2;
  localparam logic [2:0] K_DS = 3'd3;
  localparam logic [2:0] K_DA = 3'd4;
  localparam logic [2:0] K_DNA = 3'd5;
  localparam logic [2:0] K_DNB = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  ch;
    logic [11:0] val;
    logic        err;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic refresh_en = 1'b0;
  logic [1:0] owner;
  logic [7:0] tcount;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int rr = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  dac_update_if bus();

  dac_update_arbiter #(.REFRESH_PERIOD(R), .TIMEOUT_CYCLES(T), .NUM_CH(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .refresh_en_i(refresh_en),
    .owner_o(owner),
    .timeout_count_o(tcount)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.a_grant) obs_q.push_back('{K_GA, 5'd0, 12'd0, 1'b0, cyc});
    if (bus.b_grant) obs_q.push_back('{K_GB, 5'd0, 12'd0, 1'b0, cyc});
    if (bus.dac_update_single) obs_q.push_back('{K_DS, bus.dac_target_channel, bus.dac_single_value, 1'b0, cyc});
    if (bus.dac_update_all) obs_q.push_back('{K_DA, 5'd0, 12'd0, 1'b0, cyc});
    if (bus.a_done) obs_q.push_back('{K_DNA, 5'd0, 12'd0, bus.a_err, cyc});
    if (bus.b_done) obs_q.push_back('{K_DNB, 5'd0, 12'd0, bus.b_err, cyc});
  end

  function automatic ev_t mk(input logic [2:0] k, input logic [4:0] c, input logic [11:0] v, input logic e, input int t);
    return '{k, c, v, e, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    ev_t o;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if ({owner, tcount, bus.a_grant, bus.a_done, bus.a_err, bus.b_grant, bus.b_done, bus.b_err,
         bus.dac_update_single, bus.dac_update_all, bus.dac_target_channel, bus.dac_single_value} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: owner=%0d tcount=%0d ch=%0d val=%h, want all 0", owner, tcount, bus.dac_target_channel, bus.dac_single_value);
    end
    repeat (5) tick();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      o = obs_q[0];
      $display("FAIL reset idle: %0d events (first %h), want 0", obs_q.size(), o);
      obs_q.delete();
    end
  endtask

  task automatic test_single();
    int t0;
    ev_t e, o;
    t0 = cyc;
    bus.a_req = 1'b1;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd5;
    bus.a_value = 12'h7FF;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t0 + 1));
    exp_q.push_back(mk(K_DS, 5'd5, 12'h7FF, 1'b0, t0 + 1));
    exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b0, t0 + 102));
    rr = 1;
    tick();
    bus.a_req = 1'b0;
    n_cmp++;
    if (owner !== 2'd1) begin
      n_bad++;
      $display("FAIL single owner busy: got %0d want 1", owner);
    end
    wait_cyc(t0 + 101);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    tick();
    n_cmp++;
    if (owner !== 2'd0) begin
      n_bad++;
      $display("FAIL single owner idle: got %0d want 0", owner);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL single extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fairness();
    int t0, iss;
    ev_t e, o;
    t0 = cyc;
    iss = t0;
    bus.a_req = 1'b1;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd3;
    bus.a_value = 12'h123;
    bus.b_req = 1'b1;
    bus.b_all = 1'b1;
    bus.b_channel = 5'd0;
    bus.b_value = 12'h000;
    for (int i = 0; i < 8; i++) begin
      iss = t0 + 1 + 13 * i;
      if (rr == 1) begin
        exp_q.push_back(mk(K_GB, 5'd0, 12'd0, 1'b0, iss));
        exp_q.push_back(mk(K_DA, 5'd0, 12'd0, 1'b0, iss));
        exp_q.push_back(mk(K_DNB, 5'd0, 12'd0, 1'b0, iss + 11));
        rr = 2;
      end else begin
        exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, iss));
        exp_q.push_back(mk(K_DS, 5'd3, 12'h123, 1'b0, iss));
        exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b0, iss + 11));
        rr = 1;
      end
      wait_cyc(iss + 10);
      bus.dac_update_complete = 1'b1;
      tick();
      bus.dac_update_complete = 1'b0;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    wait_cyc(iss + 14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL fairness event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL fairness extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_invalid();
    int t;
    ev_t e, o;
    t = cyc;
    bus.b_req = 1'b1;
    bus.b_all = 1'b0;
    bus.b_channel = 5'd24;
    bus.b_value = 12'h555;
    exp_q.push_back(mk(K_GB, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DNB, 5'd0, 12'd0, 1'b1, t + 2));
    tick();
    bus.b_req = 1'b0;
    wait_cyc(t + 3);
    n_cmp++;
    if ({bus.dac_target_channel, bus.dac_single_value} !== {5'd3, 12'h123}) begin
      n_bad++;
      $display("FAIL invalid hold: got ch=%0d val=%h want ch=3 val=123", bus.dac_target_channel, bus.dac_single_value);
    end
    t = cyc;
    bus.b_req = 1'b1;
    bus.b_channel = 5'd23;
    bus.b_value = 12'hABC;
    exp_q.push_back(mk(K_GB, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DS, 5'd23, 12'hABC, 1'b0, t + 1));
    exp_q.push_back(mk(K_DNB, 5'd0, 12'd0, 1'b0, t + 4));
    tick();
    bus.b_req = 1'b0;
    wait_cyc(t + 3);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    repeat (2) tick();
    bus.dac_busy = 1'b1;
    bus.b_req = 1'b1;
    bus.b_channel = 5'd1;
    repeat (3) tick();
    bus.b_req = 1'b0;
    tick();
    bus.dac_busy = 1'b0;
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL invalid event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL invalid extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    int t;
    ev_t e, o;
    t = cyc;
    bus.a_req = 1'b1;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd1;
    bus.a_value = 12'h001;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DS, 5'd1, 12'h001, 1'b0, t + 1));
    exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b1, t + T + 2));
    tick();
    bus.a_req = 1'b0;
    wait_cyc(t + T + 2);
    n_cmp++;
    if (tcount !== 8'd1) begin
      n_bad++;
      $display("FAIL timeout count: got %0d want 1", tcount);
    end
    repeat (3) tick();
    t = cyc;
    bus.a_req = 1'b1;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DS, 5'd1, 12'h001, 1'b0, t + 1));
    exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b0, t + T + 2));
    tick();
    bus.a_req = 1'b0;
    wait_cyc(t + T + 1);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    n_cmp++;
    if (tcount !== 8'd1) begin
      n_bad++;
      $display("FAIL timeout tie count: got %0d want 1", tcount);
    end
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL timeout event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_refresh();
    int t, iss;
    ev_t e, o;
    t = cyc;
    refresh_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iss = t + R + 1 + R * k;
      exp_q.push_back(mk(K_DA, 5'd0, 12'd0, 1'b0, iss));
      wait_cyc(iss);
      n_cmp++;
      if (owner !== 2'd3) begin
        n_bad++;
        $display("FAIL refresh owner %0d: got %0d want 3", k, owner);
      end
      wait_cyc(iss + 2);
      bus.dac_update_complete = 1'b1;
      tick();
      bus.dac_update_complete = 1'b0;
    end
    wait_cyc(t + 160);
    bus.a_req = 1'b1;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd7;
    bus.a_value = 12'h0F0;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t + 161));
    exp_q.push_back(mk(K_DS, 5'd7, 12'h0F0, 1'b0, t + 161));
    exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b0, t + 272));
    exp_q.push_back(mk(K_DA, 5'd0, 12'd0, 1'b0, t + 274));
    exp_q.push_back(mk(K_DA, 5'd0, 12'd0, 1'b0, t + 6 * R + 1));
    tick();
    bus.a_req = 1'b0;
    wait_cyc(t + 271);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    wait_cyc(t + 274);
    n_cmp++;
    if (owner !== 2'd3) begin
      n_bad++;
      $display("FAIL refresh owner after A: got %0d want 3", owner);
    end
    wait_cyc(t + 276);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    wait_cyc(t + 6 * R + 3);
    bus.dac_update_complete = 1'b1;
    tick();
    refresh_en = 1'b0;
    bus.dac_update_complete = 1'b0;
    wait_cyc(t + 6 * R + 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL refresh event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL refresh extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int t;
    ev_t e, o;
    t = cyc;
    bus.a_req = 1'b1;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd2;
    bus.a_value = 12'h222;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DS, 5'd2, 12'h222, 1'b0, t + 1));
    tick();
    bus.a_req = 1'b0;
    wait_cyc(t + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({owner, tcount, bus.a_grant, bus.a_done, bus.a_err, bus.b_grant, bus.b_done, bus.b_err,
         bus.dac_update_single, bus.dac_update_all, bus.dac_target_channel, bus.dac_single_value} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: owner=%0d tcount=%0d ch=%0d val=%h, want all 0", owner, tcount, bus.dac_target_channel, bus.dac_single_value);
    end
    t = cyc;
    bus.a_req = 1'b1;
    bus.a_channel = 5'd9;
    bus.a_value = 12'h999;
    bus.b_req = 1'b1;
    bus.b_all = 1'b0;
    bus.b_channel = 5'd4;
    bus.b_value = 12'h444;
    exp_q.push_back(mk(K_GA, 5'd0, 12'd0, 1'b0, t + 1));
    exp_q.push_back(mk(K_DS, 5'd9, 12'h999, 1'b0, t + 1));
    exp_q.push_back(mk(K_DNA, 5'd0, 12'd0, 1'b0, t + 4));
    exp_q.push_back(mk(K_GB, 5'd0, 12'd0, 1'b0, t + 6));
    exp_q.push_back(mk(K_DS, 5'd4, 12'h444, 1'b0, t + 6));
    exp_q.push_back(mk(K_DNB, 5'd0, 12'd0, 1'b0, t + 9));
    tick();
    bus.a_req = 1'b0;
    wait_cyc(t + 3);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    wait_cyc(t + 6);
    bus.b_req = 1'b0;
    wait_cyc(t + 8);
    bus.dac_update_complete = 1'b1;
    tick();
    bus.dac_update_complete = 1'b0;
    wait_cyc(t + 12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_mid event: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid extra: %0d surplus events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    bus.a_req = 1'b0;
    bus.a_all = 1'b0;
    bus.a_channel = 5'd0;
    bus.a_value = 12'd0;
    bus.b_req = 1'b0;
    bus.b_all = 1'b0;
    bus.b_channel = 5'd0;
    bus.b_value = 12'd0;
    bus.dac_busy = 1'b0;
    bus.dac_update_complete = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_invalid();
    test_timeout();
    test_refresh();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
